subtree_event_collector: RTL and testbench
==========================================

# subtree_event_collector

Aggregation stage placed directly above a node of the generated module tree. It consumes event beats from up to five child instances (`inst_0`..`inst_4`) and forwards them one at a time to the parent level. Arbitration is round-robin. Each event is tagged with the index of the child that produced it. A small FIFO decouples child bursts from parent back-pressure.

## Interface
- `NUM_CHILD`, default 5: number of child event ports (1..8).
- `DATA_W`, default 8: event payload width.
- `FIFO_DEPTH`, default 4: collector FIFO depth. Must be a power of 2 and at least 2.
- `clk`, input, 1: single clock. All logic is rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `child_valid`, input, `NUM_CHILD`: per-child event valid.
- `child_data`, input, `NUM_CHILD*DATA_W`: packed payloads. Child i occupies bits `[i*DATA_W +: DATA_W]`.
- `child_ready`, output, `NUM_CHILD`: one-hot grant, or all zero.
- `out_valid`, output, 1: head event available.
- `out_data`, output, `IDX_W+DATA_W`: `{child_idx, payload}`, where `IDX_W = $clog2(NUM_CHILD)` (minimum 1).
- `out_ready`, input, 1: parent accepts the head event.
- `fifo_level`, output, `$clog2(FIFO_DEPTH)+1`: current occupancy.

## Operation
- **Beat transfer:** a beat moves on any port where valid && ready is high at a rising edge.
- **Arbiter:**
  - Round-robin priority pointer `rr_ptr` (0..NUM_CHILD-1).
  - Grants the first asserted `child_valid` at or after `rr_ptr`, wrapping modulo NUM_CHILD.
  - Grants only when `fifo_level < FIFO_DEPTH`.
  - `child_ready` is combinational from `child_valid`, `rr_ptr` and the full flag. It must not depend on `child_valid` of the granted child only.
  - On a grant to child g, `rr_ptr` becomes `(g+1) mod NUM_CHILD`. With no grant, `rr_ptr` holds.
- **FIFO:**
  - Push on grant, writing `{g, child_data[g]}`.
  - Pop on `out_valid && out_ready`.
  - Push and pop in the same cycle leave the level unchanged. This is legal at any level below full.
  - At full, push is blocked even if a pop occurs that cycle. There is no fall-through.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - `fifo_level` is an explicit counter, not derived from the pointers.
- **Outputs:**
  - `out_valid = (fifo_level != 0)`.
  - `out_data` shows the head entry when valid and is forced to 0 when empty.
  - `out_data` is stable while `out_valid && !out_ready`.
- **Child protocol:** children must hold valid and data until ready. A child that drops valid without ready loses the beat; the block does not detect this.

## Timing
- **Reset (asynchronous assert, synchronous release by system):**
  - `rr_ptr=0`, both FIFO pointers 0, `fifo_level=0`.
  - `out_valid=0`, `out_data=0`, `child_ready=0`.
- **Latency:** a beat accepted at edge N is visible on `out_valid`/`out_data` after edge N, so it can be consumed at edge N+1.
- **Throughput:** one push and one pop per cycle.
- **Full:** `child_ready` is all zero until a pop lowers the level. The first grant is one cycle after that pop edge.
- **Reset mid-operation:** all queued events are discarded and the arbiter restarts at child 0. No partial beat is emitted afterwards.

## Configuration
- Macro: `SUBTREE_COLLECTOR_STATS_EN`.
- **Defined:**
  - Adds output `child_evt_cnt`, width `NUM_CHILD*16`, with one 16-bit counter per child.
  - A counter increments on each accepted beat from that child and saturates at 0xFFFF.
  - Counters reset to 0.
- **Undefined:** the port and the counters are absent. All other behaviour is identical.

## Structure
- Package `subtree_collector_pkg` holds:
  - the `IDX_W` computation function;
  - typedef `evt_tag_t` (`{idx, payload}`), parameterised through localparams;
  - constant `STATS_CNT_W=16`.
- Sub-module `collector_fifo` is a synchronous FIFO with level counter. It has valid/ready on both sides, a no-fall-through full rule, and zero output when empty.
- The arbiter stays inline in the top.

## Test plan
- **Single beat:** reset, child 2 presents 0x5A with `out_ready=1` → `child_ready=5'b00100` for one cycle; next cycle `out_valid=1`, `out_data={3'd2,8'h5A}`; `fifo_level` reads 1 then 0.
- **All children valid:** all five children valid continuously, `out_ready=1` → grants cycle 0,1,2,3,4,0; tags emerge in that order.
- **Fill and release:** `out_ready=0`, child 0 streams 6 beats → 4 accepted, `fifo_level=4`, `child_ready=0` from then on. Raising `out_ready` → beats drain in order; a grant resumes one cycle after the first pop.
- **Simultaneous push/pop:** at level 2, one push and one pop in the same cycle → level stays 2 and ordering is preserved.
- **Reset mid-operation:** assert `rst_n=0` at level 3 → immediately `out_valid=0`, `out_data=0`, `fifo_level=0`; after release, child 4 is granted before child 0 only if child 0 is not valid.
- **Stats (with `SUBTREE_COLLECTOR_STATS_EN`):** child 1 sends 70000 beats → its counter reads 0xFFFF; the other counters read 0.

Source files
------------

// File: rtl/subtree_collector_pkg.sv
// Shared definitions for the subtree event collector: tag geometry helper,
// the default-geometry event tag type and the statistics counter width.
package subtree_collector_pkg;

    // Tag width for a given child count; a single child still gets one bit.
    function automatic int idx_width(input int num_child);
        return (num_child <= 2) ? 1 : $clog2(num_child);
    endfunction

    localparam int STATS_CNT_W   = 16;
    localparam int DEF_NUM_CHILD = 5;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_IDX_W     = idx_width(DEF_NUM_CHILD);

    typedef struct packed {
        logic [DEF_IDX_W-1:0]  idx;
        logic [DEF_DATA_W-1:0] payload;
    } evt_tag_t;

endpackage

// File: rtl/collector_fifo.sv
// Synchronous FIFO with an explicit level counter, no fall-through at full,
// and a zeroed output word while empty.
module collector_fifo
    import subtree_collector_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push, pop;

    // Full blocks the push even when a pop happens in the same cycle.
    assign in_ready  = (level_q != LVL_W'(DEPTH));
    assign out_valid = (level_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign level     = level_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is deliberately not reset; out_data is masked while empty, so stale words never escape.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: rtl/subtree_event_collector.sv
// Round-robin collector of child event beats into a tagged FIFO toward the parent.
// Optional per-child event counters are enabled with SUBTREE_COLLECTOR_STATS_EN.
module subtree_event_collector
    import subtree_collector_pkg::*;
#(
    parameter int NUM_CHILD  = 5,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_CHILD-1:0]                  child_valid,
    input  logic [NUM_CHILD*DATA_W-1:0]           child_data,
    output logic [NUM_CHILD-1:0]                  child_ready,
    output logic                                  out_valid,
    output logic [idx_width(NUM_CHILD)+DATA_W-1:0] out_data,
    input  logic                                  out_ready,
    output logic [$clog2(FIFO_DEPTH):0]           fifo_level
`ifdef SUBTREE_COLLECTOR_STATS_EN
    ,
    output logic [NUM_CHILD*STATS_CNT_W-1:0]      child_evt_cnt
`endif
);

    localparam int IDX_W = idx_width(NUM_CHILD);
    localparam int TAG_W = IDX_W + DATA_W;

    logic [DATA_W-1:0]    payload [NUM_CHILD];
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W:0]       cand_sum;
    logic [IDX_W-1:0]     cand_idx;
    logic                 grant_vld;
    logic [IDX_W-1:0]     grant_idx;
    logic [DATA_W-1:0]    grant_payload;
    logic [NUM_CHILD-1:0] grant_oh;
    logic                 fifo_in_ready;
    logic [TAG_W-1:0]     fifo_in_data;

    for (genvar i = 0; i < NUM_CHILD; i++) begin : g_unpack
        assign payload[i] = child_data[i*DATA_W +: DATA_W];
    end

    // Scan children starting at rr_ptr, wrapping; the first valid one wins.
    always_comb begin
        cand_sum      = '0;
        cand_idx      = '0;
        grant_vld     = 1'b0;
        grant_idx     = '0;
        grant_payload = '0;
        grant_oh      = '0;
        for (int k = 0; k < NUM_CHILD; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand_sum >= (IDX_W+1)'(NUM_CHILD))
                cand_sum = cand_sum - (IDX_W+1)'(NUM_CHILD);
            cand_idx = cand_sum[IDX_W-1:0];
            if (!grant_vld && child_valid[cand_idx] && fifo_in_ready) begin
                grant_vld     = 1'b1;
                grant_idx     = cand_idx;
                grant_payload = payload[cand_idx];
            end
        end
        if (grant_vld) grant_oh[grant_idx] = 1'b1;
    end

    assign child_ready  = grant_oh;
    assign fifo_in_data = {grant_idx, grant_payload};

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld)
            rr_ptr_d = (grant_idx == IDX_W'(NUM_CHILD-1)) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end

    collector_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (grant_vld),
        .in_ready  (fifo_in_ready),
        .in_data   (fifo_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (fifo_level)
    );

`ifdef SUBTREE_COLLECTOR_STATS_EN
    logic [STATS_CNT_W-1:0] evt_cnt_q [NUM_CHILD];

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CHILD; i++) evt_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CHILD; i++)
                if (grant_oh[i] && (evt_cnt_q[i] != '1))
                    evt_cnt_q[i] <= evt_cnt_q[i] + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CHILD; i++) begin : g_stats_pack
        assign child_evt_cnt[i*STATS_CNT_W +: STATS_CNT_W] = evt_cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_subtree_event_collector.sv
// Scoreboard bench for subtree_event_collector: a bench-side arbiter/FIFO model
// predicts grants and queues expected tags that are compared as the DUT emits them.
module tb_subtree_event_collector;
    import subtree_collector_pkg::*;

    localparam int NC    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int TW    = 3 + DW;

    logic              clk;
    logic              rst_n;
    logic [NC-1:0]     child_valid;
    logic [NC*DW-1:0]  child_data;
    logic [NC-1:0]     child_ready;
    logic              out_valid;
    logic [TW-1:0]     out_data;
    logic              out_ready;
    logic [2:0]        fifo_level;
`ifdef SUBTREE_COLLECTOR_STATS_EN
    logic [NC*16-1:0]  child_evt_cnt;
`endif

    logic [DW-1:0]     cd [NC];
    logic [TW-1:0]     sb [$];
    int                m_rr;
    int                m_level;
    int                last_grant;
    int                n_checks;
    int                n_fail;
    int                grants_seen;

    subtree_event_collector #(
        .NUM_CHILD  (NC),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .child_valid (child_valid),
        .child_data  (child_data),
        .child_ready (child_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .fifo_level  (fifo_level)
`ifdef SUBTREE_COLLECTOR_STATS_EN
        ,
        .child_evt_cnt (child_evt_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        child_data = '0;
        for (int i = 0; i < NC; i++) child_data[i*DW +: DW] = cd[i];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: sample at the falling edge against the model, then let the rising edge happen.
    task automatic tick();
        logic [NC-1:0] exp_rdy;
        logic [TW-1:0] exp_tag;
        evt_tag_t      tag;
        int            g;
        @(negedge clk);
        g = -1;
        if (m_level < DEPTH) begin
            for (int k = 0; k < NC; k++) begin
                int c;
                c = (m_rr + k) % NC;
                if (g < 0 && child_valid[c]) g = c;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("child_ready", 32'(child_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(m_level != 0));
        check("fifo_level", 32'(fifo_level), 32'(m_level));
        if (m_level == 0) begin
            check("out_data_empty", 32'(out_data), 32'd0);
        end else if (out_ready) begin
            exp_tag = sb.pop_front();
            check("out_data_pop", 32'(out_data), 32'(exp_tag));
        end else begin
            check("out_data_hold", 32'(out_data), 32'(sb[0]));
        end
        if (g >= 0) begin
            tag.idx     = 3'(g);
            tag.payload = cd[g];
            sb.push_back(tag);
            m_rr = (g + 1) % NC;
            grants_seen++;
        end
        m_level = m_level + ((g >= 0) ? 1 : 0) - ((m_level != 0 && out_ready) ? 1 : 0);
        last_grant = g;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        sb.delete();
        m_rr    = 0;
        m_level = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        child_valid = '0;
        out_ready   = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        grants_seen = 0;
        last_grant  = -1;
        rst_n       = 1'b0;
        child_valid = '0;
        out_ready   = 1'b0;
        for (int i = 0; i < NC; i++) cd[i] = '0;
        model_clear();

        // Reset state.
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        check("rst_child_ready", 32'(child_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beat from child 2.
        out_ready   = 1'b1;
        cd[2]       = 8'h5A;
        child_valid = 5'b00100;
        #1;
        check("single_grant", 32'(child_ready), 32'h04);
        tick();
        child_valid = '0;
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'h25A);
        check("single_level1", 32'(fifo_level), 32'd1);
        tick();
        check("single_level0", 32'(fifo_level), 32'd0);
        tick();

        // All children valid continuously: grants rotate 0,1,2,3,4,0.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < NC; i++) cd[i] = 8'(8'h30 + i);
        child_valid = '1;
        for (int n = 0; n < 6; n++) begin
            #1;
            check("rr_order", 32'(child_ready), 32'(1 << (n % NC)));
            tick();
            if (last_grant >= 0) cd[last_grant] = cd[last_grant] + 8'h10;
        end
        child_valid = '0;
        repeat (3) tick();

        // Fill and release: child 0 offers 6 beats while the parent stalls.
        do_reset();
        out_ready   = 1'b0;
        cd[0]       = 8'h10;
        child_valid = 5'b00001;
        grants_seen = 0;
        repeat (6) begin
            tick();
            if (last_grant == 0) cd[0] = cd[0] + 8'h01;
        end
        check("fill_level", 32'(fifo_level), 32'd4);
        check("fill_ready", 32'(child_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        check("release_no_grant", 32'(last_grant == 0), 32'd0);
        #1;
        check("release_grant", 32'(child_ready), 32'h01);
        for (int n = 0; n < 20 && grants_seen < 6; n++) begin
            tick();
            if (last_grant == 0) cd[0] = cd[0] + 8'h01;
        end
        check("fill_total", 32'(grants_seen), 32'd6);
        child_valid = '0;
        repeat (6) tick();

        // Simultaneous push and pop at level 2.
        do_reset();
        out_ready   = 1'b0;
        cd[1]       = 8'hA1;
        child_valid = 5'b00010;
        tick();
        cd[1] = 8'hA2;
        tick();
        child_valid = '0;
        check("pp_level_before", 32'(fifo_level), 32'd2);
        cd[3]       = 8'hB3;
        child_valid = 5'b01000;
        out_ready   = 1'b1;
        tick();
        child_valid = '0;
        check("pp_level_after", 32'(fifo_level), 32'd2);
        repeat (4) tick();

        // Reset mid-operation at level 3.
        do_reset();
        out_ready   = 1'b0;
        child_valid = 5'b00100;
        for (int n = 0; n < 3; n++) begin
            cd[2] = 8'(8'hC0 + n);
            tick();
        end
        child_valid = '0;
        check("mid_level3", 32'(fifo_level), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_out_data", 32'(out_data), 32'd0);
        check("mid_level", 32'(fifo_level), 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cd[0]       = 8'h0D;
        cd[4]       = 8'h4D;
        child_valid = 5'b10001;
        out_ready   = 1'b1;
        #1;
        check("mid_grant_c0", 32'(child_ready), 32'h01);
        tick();
        child_valid = '0;
        repeat (2) tick();
        do_reset();
        out_ready   = 1'b1;
        child_valid = 5'b10000;
        #1;
        check("mid_grant_c4", 32'(child_ready), 32'h10);
        tick();
        child_valid = '0;
        repeat (2) tick();

        // Random traffic with protocol-compliant children.
        for (int n = 0; n < 300; n++) begin
            for (int c = 0; c < NC; c++) begin
                if (!child_valid[c] && $urandom_range(0, 2) == 0) begin
                    child_valid[c] = 1'b1;
                    cd[c]          = 8'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (last_grant >= 0) child_valid[last_grant] = 1'b0;
        end
        child_valid = '0;
        out_ready   = 1'b1;
        repeat (6) tick();
        check("drain_level", 32'(fifo_level), 32'd0);

`ifdef SUBTREE_COLLECTOR_STATS_EN
        // Counter saturation on child 1.
        do_reset();
        out_ready   = 1'b1;
        child_valid = 5'b00010;
        repeat (70000) begin
            tick();
            if (last_grant == 1) cd[1] = cd[1] + 8'h01;
        end
        child_valid = '0;
        for (int c = 0; c < NC; c++)
            check("stats_cnt", 32'(child_evt_cnt[c*16 +: 16]), (c == 1) ? 32'hFFFF : 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
